// File: rtl/led_pwm_ctrl.sv
// LED/IR PWM driver: per-channel duty and current trim, glitch-free update at period wrap; breathe ramp under LED_BREATHE_EN.
// Latency: led_pwm is registered one clock after the counter compare; writes become active at the following period_start.
// Backpressure: none, every write is accepted in the cycle it is strobed; poc gates outputs combinationally.
module led_pwm_ctrl #(
  parameter int NCH    = 3,
  parameter int PWM_W  = 8,
  parameter int CBIT_W = 4,
  parameter int DIV    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [2:0]            wr_ch,
  input  logic                  wr_sel,
  input  logic [PWM_W-1:0]      wr_data,
  input  logic                  poc,
  output logic [NCH-1:0]        led_pwm,
  output logic [NCH*CBIT_W-1:0] cbit_led,
  output logic                  period_start
);
  localparam int PRE_W = (DIV > 0) ? $clog2(DIV + 1) : 1;

  typedef struct packed {
    logic              en;
    logic [CBIT_W-1:0] cbit;
  } ch_cfg_t;

  logic [PRE_W-1:0]          presc;
  logic [PWM_W-1:0]          pwm_cnt;
  logic                      tick;
  ch_cfg_t [NCH-1:0]         cfg_sh, cfg_act;
  logic [NCH-1:0][PWM_W-1:0] duty_sh, duty_act, cmp_val;
  logic [NCH-1:0]            led_q;

  assign tick         = (presc == PRE_W'(DIV));
  assign period_start = tick && (&pwm_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Active copies load from shadow at the wrap edge, so a write in that same cycle waits a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_sh   <= '0;
      cfg_act  <= '0;
      duty_sh  <= '0;
      duty_act <= '0;
    end else begin
      if (period_start) begin
        cfg_act  <= cfg_sh;
        duty_act <= duty_sh;
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && (wr_ch == 3'(i))) begin
          if (wr_sel) cfg_sh[i] <= '{en: wr_data[CBIT_W], cbit: wr_data[CBIT_W-1:0]};
          else        duty_sh[i] <= wr_data;
        end
      end
    end
  end

`ifdef LED_BREATHE_EN
  typedef enum logic [1:0] {BR_OFF, BR_UP, BR_DOWN} br_state_t;

  br_state_t        br_st [NCH];
  logic [PWM_W-1:0] ramp  [NCH];
  logic [NCH-1:0]   br_sh;

  // The ramp steps from the shadow values, i.e. the settings that go active at this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_sh <= '0;
      for (int i = 0; i < NCH; i++) begin
        br_st[i] <= BR_OFF;
        ramp[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && wr_sel && (wr_ch == 3'(i))) br_sh[i] <= wr_data[CBIT_W+1];
        if (period_start) begin
          if (!cfg_sh[i].en || !br_sh[i]) begin
            br_st[i] <= BR_OFF;
            ramp[i]  <= '0;
          end else begin
            case (br_st[i])
              BR_OFF: begin
                br_st[i] <= BR_UP;
                ramp[i]  <= '0;
              end
              BR_UP: begin
                if (ramp[i] > duty_sh[i]) begin
                  ramp[i]  <= duty_sh[i];
                  br_st[i] <= BR_DOWN;
                end else if (ramp[i] == duty_sh[i]) begin
                  if (duty_sh[i] != '0) begin
                    ramp[i]  <= ramp[i] - 1'b1;
                    br_st[i] <= BR_DOWN;
                  end
                end else begin
                  ramp[i] <= ramp[i] + 1'b1;
                end
              end
              BR_DOWN: begin
                if (ramp[i] == '0) begin
                  br_st[i] <= BR_UP;
                  if (duty_sh[i] != '0) ramp[i] <= PWM_W'(1);
                end else begin
                  ramp[i] <= ramp[i] - 1'b1;
                end
              end
              default: br_st[i] <= BR_OFF;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    cmp_val = duty_act;
    for (int i = 0; i < NCH; i++)
      if (br_st[i] != BR_OFF) cmp_val[i] = ramp[i];
  end
`else
  assign cmp_val = duty_act;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        led_q[i] <= cfg_act[i].en && (pwm_cnt < cmp_val[i]);
    end
  end

  assign led_pwm = poc ? '0 : led_q;

  always_comb begin
    cbit_led = '0;
    for (int i = 0; i < NCH; i++)
      if (cfg_act[i].en && !poc) cbit_led[i*CBIT_W +: CBIT_W] = cfg_act[i].cbit;
  end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 Parameter NCH, default 3, number of LED/IR driver channels (1..8).
REQ-002 Parameter PWM_W, default 8, PWM counter/duty width; PWM_W >= CBIT_W+2 SHALL hold.
REQ-003 Parameter CBIT_W, default 4, current-trim code width per channel.
REQ-004 Parameter DIV, default 0, prescaler terminal count; PWM tick every DIV+1 clocks.
REQ-005 clk  input  1  single block clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-008 wr_ch  input  3  target channel index.
REQ-009 wr_sel  input  1  0 = duty register, 1 = control register.
REQ-010 wr_data  input  PWM_W  write data; control layout [CBIT_W-1:0] cbit, [CBIT_W] en, [CBIT_W+1] breathe.
REQ-011 poc  input  1  power-on-control guard; high forces every driver off.
REQ-012 led_pwm  output  NCH  per-channel PWM drive to driver cell.
REQ-013 cbit_led  output  NCH*CBIT_W  per-channel current code, channel i at [i*CBIT_W +: CBIT_W].
REQ-014 period_start  output  1  one-cycle pulse on the clock the PWM counter wraps to 0.

Function
REQ-015 Prescaler SHALL count 0..DIV and emit tick on reaching DIV, then restart at 0.
REQ-016 PWM counter (PWM_W bits) SHALL increment on each tick and wrap 2^PWM_W-1 -> 0; period_start SHALL pulse on that wrap tick.
REQ-017 Writes SHALL land in per-channel shadow registers; wr_ch >= NCH SHALL be ignored.
REQ-018 Active duty, cbit, en and breathe SHALL load from shadow only on period_start cycles (glitch-free update).
REQ-019 A write in the same cycle as period_start SHALL update shadow only and take effect at the following period_start.
REQ-020 led_pwm[i] SHALL be registered: high one clock after counter value c when en_act[i] and c < duty_act[i].
REQ-021 Duty 0 SHALL give constant low; duty 2^PWM_W-1 SHALL give high for 2^PWM_W-1 of 2^PWM_W ticks.
REQ-022 cbit_led for channel i SHALL equal cbit_act[i] when en_act[i], else 0.
REQ-023 poc high SHALL combinationally force led_pwm and cbit_led to all-zero without disturbing counters or registers.
REQ-024 Breathe channel state machine: OFF -> UP on activation with breathe=1; UP: ramp +1 per period until ramp == duty_act, then DOWN; DOWN: ramp -1 per period until 0, then UP; breathe=0 or en=0 -> OFF.
REQ-025 In breathe mode the PWM compare value SHALL be ramp, not duty_act; duty_act 0 SHALL hold ramp at 0 and stay in UP.
REQ-026 Duty lowered below ramp while in UP SHALL clamp ramp to new duty and enter DOWN at that period_start.

Reset
REQ-027 rst SHALL clear prescaler, PWM counter, all shadow/active registers, ramps and breathe states to 0/OFF.
REQ-028 During and after rst: led_pwm = 0, cbit_led = 0, period_start = 0.
REQ-029 rst mid-period SHALL abort the period; first period_start occurs 2^PWM_W ticks after release.

Configuration
REQ-030 Macro LED_BREATHE_EN: defined -> REQ-024..026 breathe logic present; undefined -> breathe bit ignored, compare value always duty_act, no ramp/state registers.

Verification
REQ-031 DIV=0, ch0 duty=64, en=1, cbit=5 -> after next period_start led_pwm[0] high 64 of 256 clocks, cbit_led[3:0]=5.
REQ-032 Write duty=200 mid-period while duty=64 active -> current period keeps 64, next period 200.
REQ-033 Write coinciding with period_start -> new value applied one period later.
REQ-034 poc pulse high 10 clocks during active PWM -> all outputs 0 those cycles, counter continuity preserved (period_start spacing unchanged).
REQ-035 LED_BREATHE_EN, breathe=1, duty=3 -> ramp sequence per period 0,1,2,3,2,1,0,1,...; write wr_ch=7 with NCH=3 -> no state change.
REQ-036 rst asserted mid-period with duty=128 -> outputs 0 asynchronously, first period_start 256 ticks after release.
